mcyc_ctrl: RTL and testbench

MCYC_CTRL -- requirements
Module: mcyc_ctrl

---
 rtl/mcyc_ctrl_pkg.sv | 21 ++
 rtl/mcyc_ctrl_hs_timer.sv | 27 ++
 rtl/mcyc_ctrl.sv | 132 +++++++++++++
 tb/tb_mcyc_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcyc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, next-PC
// select codes and the default handshake timeout.
package mcyc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  localparam logic [1:0] PcSelSeq  = 2'b00;  // pc + 4
  localparam logic [1:0] PcSelImm  = 2'b01;  // pc + imm
  localparam logic [1:0] PcSelJalr = 2'b10;  // jalr target

  localparam int unsigned TmoCycDefault = 255;

endpackage

// File: rtl/mcyc_ctrl_hs_timer.sv
// Handshake wait counter: counts stalled cycles and flags the cycle whose
// stall would reach the limit.
module hs_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else if (clear) begin
      cnt_q <= 8'd0;
    end else if (inc) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // A cycle with ready/ack never increments, so it can never expire.
  assign expired = inc && !clear && ((cnt_q + 8'd1) == limit);

endmodule

// File: rtl/mcyc_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional
// memory access and write-back, with handshake timeouts and sticky halt.
module mcyc_ctrl
  import mcyc_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYC = TmoCycDefault
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ir,
  input  logic        i_dec_jal,
  input  logic        i_dec_jalr,
  input  logic        i_dec_brch,
  input  logic        i_dec_mem_rden,
  input  logic        i_dec_mem_wren,
  input  logic        i_dec_illegal,
  input  logic        i_dec_ebreak,
  input  logic        i_brch_taken,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_rf_wen,
  output logic        o_pc_en,
  output logic [1:0]  o_pc_sel,
  output logic        o_halt,
  output logic        o_err,
  output logic [2:0]  o_state
);

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic        taken_q;
  logic        err_q;
  logic        ir_load;
  logic        err_set;
  logic        tmr_clear, tmr_inc, tmr_expired;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
      ir_q    <= 32'd0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= i_imem_rdata;
      if (state_q == StExec) taken_q <= i_brch_taken;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Counter is held at zero outside the waiting states, so it starts at zero on entry.
  assign tmr_clear = !((state_q == StFetch) || (state_q == StMem));
  assign tmr_inc   = ((state_q == StFetch) && !i_imem_ready) ||
                     ((state_q == StMem) && !i_dmem_ack);

  hs_timer u_hs_timer (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (tmr_clear),
    .inc     (tmr_inc),
    .limit   (TMO_CYC[7:0]),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    ir_load    = 1'b0;
    err_set    = 1'b0;
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_wen   = 1'b0;
    o_pc_en    = 1'b0;
    o_pc_sel   = PcSelSeq;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        o_imem_req = 1'b1;
        if (i_imem_ready) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end else if (tmr_expired) begin
          err_set = 1'b1;
          state_d = StHalt;
        end
      end
      StDecode: begin
        if (i_dec_ebreak) begin
          state_d = StHalt;
        end else if (i_dec_illegal) begin
          err_set = 1'b1;
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: state_d = (i_dec_mem_rden || i_dec_mem_wren) ? StMem : StWb;
      StMem: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_dec_mem_wren;
        if (i_dmem_ack) begin
          state_d = StWb;
        end else if (tmr_expired) begin
          err_set = 1'b1;
          state_d = StHalt;
        end
      end
      StWb: begin
        o_pc_en  = 1'b1;
        o_rf_wen = !(i_dec_mem_wren || i_dec_brch);
        if (i_dec_jal || (i_dec_brch && taken_q)) begin
          o_pc_sel = PcSelImm;
        end else if (i_dec_jalr) begin
          o_pc_sel = PcSelJalr;
        end
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  assign o_ir    = ir_q;
  assign o_halt  = (state_q == StHalt);
  assign o_err   = err_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Directed self-checking bench for mcyc_ctrl with a 4-cycle handshake timeout.
module tb_mcyc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready;
  logic [31:0] imem_rdata, ir;
  logic        jal, jalr, brch, rden, wren, illegal, ebreak, taken;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        rf_wen, pc_en, halt, err;
  logic [1:0]  pc_sel;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mcyc_ctrl #(.TMO_CYC(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_imem_req     (imem_req),
    .i_imem_ready   (imem_ready),
    .i_imem_rdata   (imem_rdata),
    .o_ir           (ir),
    .i_dec_jal      (jal),
    .i_dec_jalr     (jalr),
    .i_dec_brch     (brch),
    .i_dec_mem_rden (rden),
    .i_dec_mem_wren (wren),
    .i_dec_illegal  (illegal),
    .i_dec_ebreak   (ebreak),
    .i_brch_taken   (taken),
    .o_dmem_req     (dmem_req),
    .o_dmem_we      (dmem_we),
    .i_dmem_ack     (dmem_ack),
    .o_rf_wen       (rf_wen),
    .o_pc_en        (pc_en),
    .o_pc_sel       (pc_sel),
    .o_halt         (halt),
    .o_err          (err),
    .o_state        (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in FETCH: instruction ready on the first request cycle.
  task automatic fetch(input logic [31:0] word, input string tag);
    imem_rdata = word;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk({tag, "_decode_state"}, {29'd0, state}, 32'd2);
    chk({tag, "_ir"}, ir, word);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    jal = 0; jalr = 0; brch = 0; rden = 0; wren = 0;
    illegal = 0; ebreak = 0; taken = 0; dmem_ack = 0;

    // Reset state
    tick();
    tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_flags", {28'd0, halt, err, imem_req, dmem_req}, 32'd0);
    chk("rst_strobes", {29'd0, rf_wen, pc_en, dmem_we}, 32'd0);
    rst = 1'b1;
    chk("rel_idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("rel_fetch_state", {29'd0, state}, 32'd1);
    chk("rel_fetch_req", {31'd0, imem_req}, 32'd1);

    // addi: 1,2,3,5,1
    fetch(32'h0050_0093, "addi");
    chk("addi_dec_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("addi_exec", {29'd0, state}, 32'd3);
    tick();
    chk("addi_wb", {29'd0, state}, 32'd5);
    chk("addi_wb_strobes", {29'd0, rf_wen, pc_en, dmem_req}, 32'b110);
    chk("addi_pc_sel", {30'd0, pc_sel}, 32'd0);
    tick();
    chk("addi_back_fetch", {29'd0, state}, 32'd1);
    chk("addi_fetch_strobes", {30'd0, rf_wen, pc_en}, 32'd0);

    // lw with ack on the 4th MEM cycle, coinciding with the timeout cycle
    fetch(32'h0000_a103, "lw");
    rden = 1'b1;
    tick();
    tick();
    chk("lw_mem_c1", {29'd0, state, dmem_req, dmem_we} >> 0, {27'd0, 3'd4, 1'b1, 1'b0});
    tick();
    chk("lw_mem_c2", {30'd0, dmem_req, dmem_we}, 32'b10);
    tick();
    chk("lw_mem_c3", {30'd0, dmem_req, dmem_we}, 32'b10);
    tick();
    chk("lw_mem_c4", {30'd0, dmem_req, dmem_we}, 32'b10);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lw_wb_state", {29'd0, state}, 32'd5);
    chk("lw_wb", {28'd0, rf_wen, pc_en, dmem_req, err}, 32'b1100);
    rden = 1'b0;
    tick();

    // sw: write enable, no register write
    fetch(32'h0020_a023, "sw");
    wren = 1'b1;
    tick();
    tick();
    chk("sw_mem", {29'd0, state}, 32'd4);
    chk("sw_we", {30'd0, dmem_req, dmem_we}, 32'b11);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("sw_wb", {29'd0, state}, 32'd5);
    chk("sw_wb_strobes", {30'd0, rf_wen, pc_en}, 32'b01);
    wren = 1'b0;
    tick();

    // beq taken; taken drops in WB to show it was registered in EXEC
    fetch(32'h0020_8463, "beq_t");
    brch = 1'b1; taken = 1'b1;
    tick();
    tick();
    taken = 1'b0;
    chk("beq_t_sel", {30'd0, pc_sel}, 32'b01);
    chk("beq_t_rf", {30'd0, rf_wen, pc_en}, 32'b01);
    tick();

    // beq not taken
    fetch(32'h0020_8463, "beq_n");
    tick();
    tick();
    chk("beq_n_sel", {30'd0, pc_sel}, 32'b00);
    chk("beq_n_rf", {31'd0, rf_wen}, 32'd0);
    brch = 1'b0;
    tick();

    // jalr
    fetch(32'h0000_80e7, "jalr");
    jalr = 1'b1;
    tick();
    tick();
    chk("jalr_sel", {30'd0, pc_sel}, 32'b10);
    chk("jalr_rf", {31'd0, rf_wen}, 32'd1);
    jalr = 1'b0;
    tick();

    // jal
    fetch(32'h0080_00ef, "jal");
    jal = 1'b1;
    tick();
    tick();
    chk("jal_sel", {30'd0, pc_sel}, 32'b01);
    chk("jal_rf", {31'd0, rf_wen}, 32'd1);
    jal = 1'b0;
    tick();
    chk("jal_sel_outside_wb", {30'd0, pc_sel}, 32'd0);

    // Reset in the middle of a MEM wait
    fetch(32'h0000_a103, "lw_rst");
    rden = 1'b1;
    tick();
    tick();
    tick();
    chk("lw_rst_in_mem", {29'd0, state}, 32'd4);
    rst = 1'b0;
    tick();
    rden = 1'b0;
    chk("mid_rst_state", {29'd0, state}, 32'd0);
    chk("mid_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    rst = 1'b1;
    chk("mid_rel_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    chk("mid_rel_req_high", {31'd0, imem_req}, 32'd1);

    // ebreak: halt without error, stays silent
    fetch(32'h0010_0073, "ebreak");
    ebreak = 1'b1;
    tick();
    ebreak = 1'b0;
    chk("ebreak_state", {29'd0, state}, 32'd6);
    chk("ebreak_flags", {30'd0, halt, err}, 32'b10);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'b1;
      chk("ebreak_quiet", {28'd0, imem_req, dmem_req, rf_wen, pc_en}, 32'd0);
      tick();
    end
    imem_ready = 1'b0;
    chk("ebreak_absorb", {29'd0, state}, 32'd6);

    // illegal opcode
    do_reset();
    tick();
    fetch(32'hffff_ffff, "illegal");
    illegal = 1'b1;
    tick();
    illegal = 1'b0;
    chk("illegal_flags", {29'd0, state}, 32'd6);
    chk("illegal_err", {30'd0, halt, err}, 32'b11);

    // Fetch timeout: four request cycles without ready
    do_reset();
    tick();
    chk("tmo_c1", {29'd0, state}, 32'd1);
    tick();
    tick();
    tick();
    chk("tmo_c4", {30'd0, state == 3'd1, imem_req}, 32'b11);
    tick();
    chk("tmo_halt", {29'd0, state}, 32'd6);
    chk("tmo_err", {30'd0, halt, err}, 32'b11);
    chk("tmo_req_low", {31'd0, imem_req}, 32'd0);

    // Ready on the 4th fetch cycle wins over the timeout
    do_reset();
    chk("rst_clears_err", {30'd0, halt, err}, 32'd0);
    tick();
    tick();
    tick();
    tick();
    fetch(32'h1234_5678, "late_ready");
    chk("late_ready_no_err", {31'd0, err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
